// File: rtl/reg_mgt_mc.sv
// Multi-channel TLK2711 register manager: per-link config banks, sticky W1C interrupts,
// RX event FIFO and soft-reset pulse. Define REG_MGT_MC_READBACK_EN to read back link config.
module reg_mgt_mc #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned EVT_DEPTH       = 16,
  parameter int unsigned SOFT_RST_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_reg_wen,
  input  logic [15:0]                i_reg_waddr,
  input  logic [63:0]                i_reg_wdata,
  input  logic                       i_reg_ren,
  input  logic [15:0]                i_reg_raddr,
  output logic [63:0]                o_reg_rdata,
  output logic                       o_reg_rvalid,
  output logic                       o_irq,
  output logic                       o_soft_rst,
  output logic [N_CH*ADDR_WIDTH-1:0] o_tx_base_addr,
  output logic [N_CH*32-1:0]         o_tx_total_packet,
  output logic [N_CH*16-1:0]         o_tx_packet_body,
  output logic [N_CH*16-1:0]         o_tx_packet_tail,
  output logic [N_CH*16-1:0]         o_tx_body_num,
  output logic [N_CH*4-1:0]          o_tx_mode,
  output logic [N_CH-1:0]            o_tx_start,
  output logic [N_CH*ADDR_WIDTH-1:0] o_rx_base_addr,
  output logic [N_CH-1:0]            o_rx_start,
  input  logic [N_CH-1:0]            i_tx_done,
  input  logic [N_CH-1:0]            i_rx_done,
  input  logic [N_CH-1:0]            i_loss,
  input  logic [N_CH*16-1:0]         i_rx_frame_length,
  input  logic [N_CH*16-1:0]         i_rx_frame_num,
  input  logic [N_CH*10-1:0]         i_tx_status,
  input  logic [N_CH*6-1:0]          i_rx_status
);

  localparam int unsigned PtrW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SrW  = $clog2(SOFT_RST_CYCLES + 1);

  localparam logic [15:0] AddrSoftRst   = 16'h0000;
  localparam logic [15:0] AddrIrqStatus = 16'h0008;
  localparam logic [15:0] AddrIrqMask   = 16'h0010;
  localparam logic [15:0] AddrEvtPop    = 16'h0018;
  localparam logic [15:0] AddrEvtInfo   = 16'h0020;

  localparam logic [7:0] OffCtrl     = 8'h00;
  localparam logic [7:0] OffTxAddr   = 8'h08;
  localparam logic [7:0] OffTxLength = 8'h10;
  localparam logic [7:0] OffTxPacket = 8'h18;
  localparam logic [7:0] OffRxAddr   = 8'h20;
  localparam logic [7:0] OffStatus   = 8'h28;

  function automatic logic [63:0] evt_entry(input int unsigned ch, input logic [31:0] info);
    return {4'd2, 4'(ch), 24'h0, info};
  endfunction

  // Address decode
  logic [3:0] wr_ch, rd_ch;
  logic       wr_link, rd_link;

  assign wr_ch   = i_reg_waddr[11:8];
  assign rd_ch   = i_reg_raddr[11:8];
  assign wr_link = i_reg_wen && (i_reg_waddr[15:12] == 4'h1) && ({28'b0, wr_ch} < N_CH);
  assign rd_link = (i_reg_raddr[15:12] == 4'h1) && ({28'b0, rd_ch} < N_CH);

  // Per-link configuration bank
  logic [ADDR_WIDTH-1:0] tx_addr_q [N_CH];
  logic [31:0]           tx_len_q  [N_CH];
  logic [15:0]           tx_body_q [N_CH];
  logic [15:0]           tx_num_q  [N_CH];
  logic [15:0]           tx_tail_q [N_CH];
  logic [3:0]            tx_mode_q [N_CH];
  logic [ADDR_WIDTH-1:0] rx_addr_q [N_CH];
  logic [N_CH-1:0]       tx_start_req_q, rx_start_req_q, tx_start_q, rx_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        tx_addr_q[c] <= '0;
        tx_len_q[c]  <= '0;
        tx_body_q[c] <= '0;
        tx_num_q[c]  <= '0;
        tx_tail_q[c] <= '0;
        tx_mode_q[c] <= '0;
        rx_addr_q[c] <= '0;
      end
      tx_start_req_q <= '0;
      rx_start_req_q <= '0;
      tx_start_q     <= '0;
      rx_start_q     <= '0;
    end else begin
      // Start pulses trail the CTRL write by one cycle so config is stable first
      tx_start_q <= tx_start_req_q;
      rx_start_q <= rx_start_req_q;
      for (int c = 0; c < N_CH; c++) begin
        tx_start_req_q[c] <= 1'b0;
        rx_start_req_q[c] <= 1'b0;
        if (wr_link && (wr_ch == 4'(c))) begin
          case (i_reg_waddr[7:0])
            OffCtrl: begin
              tx_start_req_q[c] <= i_reg_wdata[0];
              rx_start_req_q[c] <= i_reg_wdata[1];
            end
            OffTxAddr:   tx_addr_q[c] <= i_reg_wdata[ADDR_WIDTH-1:0];
            OffTxLength: tx_len_q[c]  <= i_reg_wdata[31:0];
            OffTxPacket: begin
              tx_body_q[c] <= i_reg_wdata[15:0];
              tx_num_q[c]  <= i_reg_wdata[31:16];
              tx_tail_q[c] <= i_reg_wdata[47:32];
              tx_mode_q[c] <= i_reg_wdata[63:60];
            end
            OffRxAddr:   rx_addr_q[c] <= i_reg_wdata[ADDR_WIDTH-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    o_tx_base_addr    = '0;
    o_tx_total_packet = '0;
    o_tx_packet_body  = '0;
    o_tx_packet_tail  = '0;
    o_tx_body_num     = '0;
    o_tx_mode         = '0;
    o_rx_base_addr    = '0;
    for (int c = 0; c < N_CH; c++) begin
      o_tx_base_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = tx_addr_q[c];
      o_tx_total_packet[c*32 +: 32]              = tx_len_q[c];
      o_tx_packet_body[c*16 +: 16]               = tx_body_q[c];
      o_tx_packet_tail[c*16 +: 16]               = tx_tail_q[c];
      o_tx_body_num[c*16 +: 16]                  = tx_num_q[c];
      o_tx_mode[c*4 +: 4]                        = tx_mode_q[c];
      o_rx_base_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = rx_addr_q[c];
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_rx_start = rx_start_q;

  // Soft reset pulse; a rewrite reloads the counter
  logic [SrW-1:0] soft_cnt_q;
  logic           soft_wr;

  assign soft_wr = i_reg_wen && (i_reg_waddr == AddrSoftRst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soft_cnt_q <= '0;
    end else if (soft_wr) begin
      soft_cnt_q <= SrW'(SOFT_RST_CYCLES);
    end else if (soft_cnt_q != '0) begin
      soft_cnt_q <= soft_cnt_q - 1'b1;
    end
  end

  assign o_soft_rst = (soft_cnt_q != '0);

  // RX event arbitration with one-deep per-link pending slots
  logic [CntW-1:0] fifo_cnt_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [63:0]     fifo_mem [EVT_DEPTH];
  logic            fifo_empty, fifo_full;
  logic            push, pop, granted, evt_ovf;
  logic [63:0]     push_data;
  logic [N_CH-1:0] slot_v_q, slot_v_d;
  logic [31:0]     slot_data_q [N_CH];
  logic [31:0]     slot_data_d [N_CH];
  logic [31:0]     rx_evt      [N_CH];

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CntW'(EVT_DEPTH));
  assign pop        = i_reg_ren && (i_reg_raddr == AddrEvtPop) && !fifo_empty;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      rx_evt[c] = {i_rx_frame_num[c*16 +: 16], i_rx_frame_length[c*16 +: 16]};
    end
  end

  always_comb begin
    slot_v_d  = slot_v_q;
    push      = 1'b0;
    push_data = '0;
    evt_ovf   = 1'b0;
    granted   = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      slot_data_d[c] = slot_data_q[c];
      if (!granted && (slot_v_q[c] || i_rx_done[c])) begin
        granted     = 1'b1;
        slot_v_d[c] = 1'b0;
        // A pop in the same cycle frees the entry this push needs
        if (fifo_full && !pop) begin
          evt_ovf = 1'b1;
        end else begin
          push      = 1'b1;
          push_data = evt_entry(c, slot_v_q[c] ? slot_data_q[c] : rx_evt[c]);
        end
        if (slot_v_q[c] && i_rx_done[c]) evt_ovf = 1'b1;
      end else if (i_rx_done[c]) begin
        if (slot_v_q[c]) begin
          evt_ovf = 1'b1;
        end else begin
          slot_v_d[c]    = 1'b1;
          slot_data_d[c] = rx_evt[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int c = 0; c < N_CH; c++) slot_data_q[c] <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      for (int c = 0; c < N_CH; c++) slot_data_q[c] <= slot_data_d[c];
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  // Sticky interrupt status; a set beats a W1C on the same bit
  logic [63:0] irq_status_q, irq_mask_q, irq_set, irq_clr;
  logic        irq_q;

  always_comb begin
    irq_set = '0;
    for (int c = 0; c < N_CH; c++) begin
      irq_set[3*c]   = i_tx_done[c];
      irq_set[3*c+1] = i_rx_done[c];
      irq_set[3*c+2] = i_loss[c];
    end
    irq_set[63] = evt_ovf;
    irq_clr     = (i_reg_wen && (i_reg_waddr == AddrIrqStatus)) ? i_reg_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= (irq_status_q & ~irq_clr) | irq_set;
      irq_q        <= |(irq_status_q & irq_mask_q);
      if (i_reg_wen && (i_reg_waddr == AddrIrqMask)) irq_mask_q <= i_reg_wdata;
    end
  end

  assign o_irq = irq_q;

  // Registered read path
  logic [63:0] rdata_d, rdata_q;
  logic        rvalid_q;

  always_comb begin
    rdata_d = '0;
    if (rd_link) begin
      for (int c = 0; c < N_CH; c++) begin
        if (rd_ch == 4'(c)) begin
          case (i_reg_raddr[7:0])
            OffStatus: rdata_d = {48'h0, i_tx_status[c*10 +: 10], i_rx_status[c*6 +: 6]};
`ifdef REG_MGT_MC_READBACK_EN
            OffTxAddr:   rdata_d = 64'(tx_addr_q[c]);
            OffTxLength: rdata_d = 64'(tx_len_q[c]);
            OffTxPacket: rdata_d = {tx_mode_q[c], 12'h0, tx_tail_q[c], tx_num_q[c], tx_body_q[c]};
            OffRxAddr:   rdata_d = 64'(rx_addr_q[c]);
`endif
            default: ;
          endcase
        end
      end
    end else begin
      case (i_reg_raddr)
        AddrIrqStatus: rdata_d = irq_status_q;
        AddrIrqMask:   rdata_d = irq_mask_q;
        AddrEvtPop:    rdata_d = fifo_empty ? 64'h0 : fifo_mem[rd_ptr_q];
        AddrEvtInfo:   rdata_d = {32'h0, 8'(slot_v_q), 6'h0, fifo_full, fifo_empty,
                                  16'(fifo_cnt_q)};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= i_reg_ren;
      if (i_reg_ren) rdata_q <= rdata_d;
    end
  end

  assign o_reg_rdata  = rdata_q;
  assign o_reg_rvalid = rvalid_q;

endmodule

// File: tb/tb_reg_mgt_mc.sv
// Self-checking bench for reg_mgt_mc: directed register/event scenarios plus a randomized
// event/pop phase checked against a queue-based reference model.
module tb_reg_mgt_mc;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int D  = 16;
  localparam int SR = 255;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wen, ren;
  logic [15:0]   waddr, raddr;
  logic [63:0]   wdata, rdata;
  logic          rvalid, irq, soft_rst;
  logic [N*AW-1:0] tx_base, rx_base;
  logic [N*32-1:0] tx_total;
  logic [N*16-1:0] body, tail, num, fl, fn;
  logic [N*4-1:0]  mode;
  logic [N-1:0]    tx_start, rx_start, tx_done, rx_done, loss;
  logic [N*10-1:0] txs;
  logic [N*6-1:0]  rxs;

  reg_mgt_mc #(.N_CH(N), .ADDR_WIDTH(AW), .EVT_DEPTH(D), .SOFT_RST_CYCLES(SR)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_reg_wen(wen), .i_reg_waddr(waddr), .i_reg_wdata(wdata),
    .i_reg_ren(ren), .i_reg_raddr(raddr), .o_reg_rdata(rdata), .o_reg_rvalid(rvalid),
    .o_irq(irq), .o_soft_rst(soft_rst),
    .o_tx_base_addr(tx_base), .o_tx_total_packet(tx_total), .o_tx_packet_body(body),
    .o_tx_packet_tail(tail), .o_tx_body_num(num), .o_tx_mode(mode), .o_tx_start(tx_start),
    .o_rx_base_addr(rx_base), .o_rx_start(rx_start),
    .i_tx_done(tx_done), .i_rx_done(rx_done), .i_loss(loss),
    .i_rx_frame_length(fl), .i_rx_frame_num(fn), .i_tx_status(txs), .i_rx_status(rxs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] mq [$];
  logic [N-1:0] pv;
  logic [31:0] pd [N];
  logic [63:0] m_status, m_mask, exp_rd, d, r;
  logic        irq_exp, do_rd, ovf, gr;
  logic [N-1:0] td, rdn, ls;
  logic [N*16-1:0] fl_v, fn_v;
  int          sel, hi;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] v);
    wen = 1'b1; waddr = a; wdata = v;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] v);
    ren = 1'b1; raddr = a;
    tick();
    ren = 1'b0;
    check("rvalid", {63'h0, rvalid}, 64'h1);
    v = rdata;
  endtask

  function automatic logic [63:0] info(input int cnt, input logic [N-1:0] p);
    logic [63:0] v;
    v = '0;
    v[15:0]  = 16'(cnt);
    v[16]    = (cnt == 0);
    v[17]    = (cnt == D);
    v[31:24] = 8'(p);
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; wen = 0; ren = 0; waddr = 0; raddr = 0; wdata = 0;
    tx_done = 0; rx_done = 0; loss = 0; fl = 0; fn = 0; txs = 0; rxs = 0;
    #23;
    check("rst_rvalid", {63'h0, rvalid}, 0);
    check("rst_irq", {63'h0, irq}, 0);
    check("rst_soft", {63'h0, soft_rst}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_txbase", tx_base[63:0], 0);
    check("rst_start", {56'h0, tx_start, rx_start}, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    rd(16'h0020, d); check("rst_evtinfo", d, 64'h1_0000);
    rd(16'h0010, d); check("rst_mask", d, 0);

    // Link 2 packetisation and start pulse
    wr(16'h1218, 64'h2000_0005_0003_0366);
    check("body", body, 64'h0000_0366_0000_0000);
    check("num", num, 64'h0000_0003_0000_0000);
    check("tail", tail, 64'h0000_0005_0000_0000);
    check("mode", {48'h0, mode}, 64'h0200);
    wr(16'h1200, 64'h1);
    check("tx_start_e0", {60'h0, tx_start}, 0);
    tick();
    check("tx_start_e1", {60'h0, tx_start}, 64'h4);
    check("rx_start_e1", {60'h0, rx_start}, 0);
    tick();
    check("tx_start_e2", {60'h0, tx_start}, 0);
    wr(16'h1300, 64'h2);
    tick();
    check("rx_start3", {56'h0, rx_start, tx_start}, 64'h80);

    r = {$urandom, $urandom};
    wr(16'h1108, r);
    wr(16'h1508, '1);
    wr(16'h1138, '1);
    wr(16'h0030, '1);
    check("txbase_hi", tx_base[127:64], 0);
    check("txbase_lo", tx_base[63:0], {r[31:0], 32'h0});
    wr(16'h1010, 64'h1234_5678);
    check("txtotal", tx_total[63:0], 64'h1234_5678);
    rd(16'h1108, d);
`ifdef REG_MGT_MC_READBACK_EN
    check("readback", d, {32'h0, r[31:0]});
`else
    check("readback", d, 0);
`endif
    txs = {$urandom, $urandom}; rxs = {$urandom};
    rd(16'h1128, d);
    check("status1", d, {48'h0, txs[19:10], rxs[11:6]});
    tick();
    check("rvalid_fall", {63'h0, rvalid}, 0);
    check("rdata_hold", rdata, d);
    rd(16'h0010, d); check("mask_unmapped_wr", d, 0);

    // Interrupt and first event
    wr(16'h0010, 64'h2);
    fl[15:0] = 16'h0100; fn[15:0] = 16'h0007; rx_done = 4'b0001;
    tick();
    rx_done = 0;
    check("irq_lag", {63'h0, irq}, 0);
    tick();
    check("irq_up", {63'h0, irq}, 1);
    rd(16'h0008, d); check("irq_status", d, 64'h2);
    rd(16'h0018, d); check("pop_first", d, 64'h2000_0000_0007_0100);
    wr(16'h0008, 64'h2);
    tick();
    check("irq_w1c", {63'h0, irq}, 0);

    // Set beats clear on the same bit
    tx_done = 4'b0010;
    wr(16'h0008, 64'h8);
    tx_done = 0;
    rd(16'h0008, d); check("set_wins", d, 64'h8);
    wr(16'h0008, 64'h8);
    rd(16'h0008, d); check("w1c_clear", d, 0);

    // Simultaneous RX events on links 0,1,3
    fl = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    fn = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    rx_done = 4'b1011;
    tick();
    rx_done = 0;
    rd(16'h0020, d); check("pend_0a", d, 64'h0A00_0001);
    rd(16'h0020, d); check("pend_08", d, 64'h0800_0002);
    rd(16'h0020, d); check("pend_00", d, 64'h0000_0003);
    rd(16'h0018, d); check("pop_ch0", d, 64'h2000_0000_0010_0100);
    rd(16'h0018, d); check("pop_ch1", d, 64'h2100_0000_0011_0101);
    rd(16'h0018, d); check("pop_ch3", d, 64'h2300_0000_0013_0103);
    rd(16'h0008, d); check("status_multi", d, 64'h412);
    wr(16'h0008, '1);

    // Overflow on a full FIFO
    fn[15:0] = 16'h00AA;
    for (int i = 0; i < D + 2; i++) begin
      fl[15:0] = 16'(i); rx_done = 4'b0001;
      tick();
    end
    rx_done = 0;
    rd(16'h0020, d); check("full_info", d, 64'h0002_0010);
    rd(16'h0008, d); check("ovf_status", d, 64'h8000_0000_0000_0002);
    for (int i = 0; i < D; i++) begin
      rd(16'h0018, d); check("drain", d, {4'd2, 4'd0, 24'h0, 16'h00AA, 16'(i)});
    end
    rd(16'h0018, d); check("pop_empty", d, 0);
    rd(16'h0020, d); check("empty_info", d, 64'h1_0000);
    wr(16'h0008, '1);

    // Randomized events and pops against the model
    m_mask = {$urandom, $urandom};
    wr(16'h0010, m_mask);
    rd(16'h0010, d); check("mask_rw", d, m_mask);
    m_status = '0; pv = '0;
    for (int c = 0; c < N; c++) pd[c] = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      td = '0; rdn = '0; ls = '0;
      if (cyc < 290) begin
        for (int c = 0; c < N; c++) begin
          td[c]  = ($urandom_range(0, 5) == 0);
          rdn[c] = ($urandom_range(0, 3) == 0);
          ls[c]  = ($urandom_range(0, 9) == 0);
        end
      end
      fl_v = {$urandom, $urandom}; fn_v = {$urandom, $urandom};
      sel = (cyc < 290) ? int'($urandom_range(0, 3)) : 3;
      do_rd = (sel < 3);
      exp_rd = '0;
      if (sel < 2) exp_rd = (mq.size() > 0) ? mq[0] : 64'h0;
      else if (sel == 2) exp_rd = info(mq.size(), pv);
      irq_exp = |(m_status & m_mask);
      if (sel < 2 && mq.size() > 0) void'(mq.pop_front());
      ovf = 1'b0; gr = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (!gr && (pv[c] || rdn[c])) begin
          gr = 1'b1;
          if (mq.size() < D)
            mq.push_back({4'd2, 4'(c), 24'h0,
                          pv[c] ? pd[c] : {fn_v[c*16 +: 16], fl_v[c*16 +: 16]}});
          else ovf = 1'b1;
          if (pv[c] && rdn[c]) ovf = 1'b1;
          pv[c] = 1'b0;
        end else if (rdn[c]) begin
          if (pv[c]) ovf = 1'b1;
          else begin
            pv[c] = 1'b1;
            pd[c] = {fn_v[c*16 +: 16], fl_v[c*16 +: 16]};
          end
        end
        m_status[3*c]   = m_status[3*c] | td[c];
        m_status[3*c+1] = m_status[3*c+1] | rdn[c];
        m_status[3*c+2] = m_status[3*c+2] | ls[c];
      end
      m_status[63] = m_status[63] | ovf;
      tx_done = td; rx_done = rdn; loss = ls; fl = fl_v; fn = fn_v;
      ren = do_rd; raddr = (sel < 2) ? 16'h0018 : 16'h0020;
      tick();
      ren = 0;
      check("rand_irq", {63'h0, irq}, {63'h0, irq_exp});
      if (do_rd) check("rand_rdata", rdata, exp_rd);
    end
    tx_done = 0; rx_done = 0; loss = 0;
    rd(16'h0008, d); check("rand_status", d, m_status);
    rd(16'h0020, d); check("rand_info", d, info(mq.size(), pv));
    while (mq.size() > 0) begin
      rd(16'h0018, d); check("rand_drain", d, mq.pop_front());
    end
    rd(16'h0020, d); check("rand_empty", d, 64'h1_0000);
    wr(16'h0008, '1);

    // Soft reset pulse with a restart 100 cycles in
    check("soft_idle", {63'h0, soft_rst}, 0);
    wr(16'h0000, 64'h1);
    hi = soft_rst ? 1 : 0;
    for (int i = 1; i < 100; i++) begin
      tick();
      if (soft_rst) hi++;
    end
    wr(16'h0000, 64'h1);
    if (soft_rst) hi++;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (soft_rst) hi++;
      else break;
    end
    check("soft_len", 64'(hi), 64'(100 + SR));
    check("soft_fall", {63'h0, soft_rst}, 0);

    // Asynchronous reset mid-read with a pending slot and live irq
    wr(16'h0010, 64'h2);
    fl = '0; fn = '0; rx_done = 4'b0001;
    tick();
    rx_done = 4'b0011; ren = 1'b1; raddr = 16'h0020;
    tick();
    rx_done = 0;
    check("pre_rst_rvalid", {63'h0, rvalid}, 1);
    check("pre_rst_irq", {63'h0, irq}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rvalid", {63'h0, rvalid}, 0);
    check("arst_irq", {63'h0, irq}, 0);
    check("arst_rdata", rdata, 0);
    ren = 0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    rd(16'h0020, d); check("arst_fifo", d, 64'h1_0000);
    rd(16'h0008, d); check("arst_status", d, 0);
    rd(16'h0010, d); check("arst_mask", d, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
